fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage with IF/ID pipeline register for the five-stage processor.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory, pipeline control and IF/ID outputs
interface fetch_unit_if #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 32
);
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_word0;
   logic [INSTR_W-1:0] imem_word1;
   logic               stall;
   logic               flush;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               int_req;
   logic               int_ack;
   logic [PC_W-1:0]    int_ret_pc;
   logic               if_id_valid;
   logic [INSTR_W-1:0] if_id_instr;
   logic [INSTR_W-1:0] if_id_imm;
   logic [PC_W-1:0]    if_id_pc_next;
   logic [PC_W-1:0]    pc_out;

   modport master (
      output imem_addr, int_ack, int_ret_pc,
      output if_id_valid, if_id_instr, if_id_imm, if_id_pc_next, pc_out,
      input  imem_word0, imem_word1, stall, flush, redirect, redirect_pc, int_req
   );

   modport slave (
      input  imem_addr, int_ack, int_ret_pc,
      input  if_id_valid, if_id_instr, if_id_imm, if_id_pc_next, pc_out,
      output imem_word0, imem_word1, stall, flush, redirect, redirect_pc, int_req
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, boot/interrupt vectoring and IF/ID register
module fetch_unit #(
   parameter int                  INSTR_W   = 16,
   parameter int                  PC_W      = 32,
   parameter int                  OPC_W     = 5,
   parameter logic [2**OPC_W-1:0] LONG_OPS  = '0,
   parameter logic [PC_W-1:0]     RESET_PTR = '0,
   parameter logic [PC_W-1:0]     INT_PTR   = PC_W'(2)
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_INTV} state_t;

   state_t             state_q;
   logic [PC_W-1:0]    pc_q;
   logic               int_pending_q;
   logic               int_ack_q;
   logic [PC_W-1:0]    int_ret_pc_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] imm_q;
   logic [PC_W-1:0]    pc_next_q;

   logic               long_d;
   logic [PC_W-1:0]    pc_seq_d;
   logic [PC_W-1:0]    vector_d;
   logic               pend_d;

   // A request on the same cycle as the check counts, so a single-cycle pulse is never missed.
   assign pend_d   = int_pending_q | bus.int_req;
   assign long_d   = LONG_OPS[bus.imem_word0[INSTR_W-1 -: OPC_W]];
   assign pc_seq_d = pc_q + (long_d ? PC_W'(2) : PC_W'(1));
   assign vector_d = PC_W'({bus.imem_word1, bus.imem_word0});

   always_comb begin
      bus.imem_addr = pc_q;
      if (state_q == S_BOOT)      bus.imem_addr = RESET_PTR;
      else if (state_q == S_INTV) bus.imem_addr = INT_PTR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_BOOT;
         pc_q          <= '0;
         int_pending_q <= 1'b0;
         int_ack_q     <= 1'b0;
         int_ret_pc_q  <= '0;
         valid_q       <= 1'b0;
         instr_q       <= '0;
         imm_q         <= '0;
         pc_next_q     <= '0;
      end else begin
         // IF/ID takes a bubble unless a branch below explicitly holds or loads it.
         int_ack_q <= 1'b0;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         imm_q     <= '0;
         pc_next_q <= '0;
         case (state_q)
            S_BOOT: begin
               pc_q          <= vector_d;
               int_pending_q <= pend_d;
               state_q       <= S_RUN;
            end
            S_INTV: begin
               pc_q          <= vector_d;
               int_pending_q <= bus.int_req;
               state_q       <= S_RUN;
            end
            default: begin
               int_pending_q <= pend_d;
               if (bus.redirect) begin
                  pc_q <= bus.redirect_pc;
               end else if (pend_d && !bus.stall) begin
                  state_q      <= S_INTV;
                  int_ack_q    <= 1'b1;
                  int_ret_pc_q <= pc_q;
               end else if (bus.stall) begin
                  if (!bus.flush) begin
                     valid_q   <= valid_q;
                     instr_q   <= instr_q;
                     imm_q     <= imm_q;
                     pc_next_q <= pc_next_q;
                  end
               end else begin
                  pc_q <= pc_seq_d;
                  if (!bus.flush) begin
                     valid_q   <= 1'b1;
                     instr_q   <= bus.imem_word0;
                     imm_q     <= long_d ? bus.imem_word1 : '0;
                     pc_next_q <= pc_seq_d;
                  end
               end
            end
         endcase
      end
   end

   assign bus.pc_out        = pc_q;
   assign bus.int_ack       = int_ack_q;
   assign bus.int_ret_pc    = int_ret_pc_q;
   assign bus.if_id_valid   = valid_q;
   assign bus.if_id_instr   = instr_q;
   assign bus.if_id_imm     = imm_q;
   assign bus.if_id_pc_next = pc_next_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - bench for fetch_unit: cycle model on a 32-bit PC instance, literal checks on both instances
module tb_fetch_unit;
   localparam int MB = 0;
   localparam int MR = 1;
   localparam int MI = 2;
   localparam logic [31:0] LONG_SET = 32'h0000_0008;

   logic clk = 1'b0;
   logic rst_n;
   logic rst8_n;
   int   total = 0;
   int   bad = 0;
   bit   chk_en = 1'b0;

   logic [15:0] mem [0:1023];
   logic [15:0] mem8 [0:255];
   logic [31:0] a1;
   logic [7:0]  a8;

   fetch_unit_if #(.INSTR_W(16), .PC_W(32)) bus ();
   fetch_unit_if #(.INSTR_W(16), .PC_W(8))  bus8 ();

   fetch_unit #(.INSTR_W(16), .PC_W(32), .OPC_W(5), .LONG_OPS(LONG_SET),
                .RESET_PTR(32'd0), .INT_PTR(32'd2))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   fetch_unit #(.INSTR_W(16), .PC_W(8), .OPC_W(5), .LONG_OPS(LONG_SET),
                .RESET_PTR(8'd0), .INT_PTR(8'd2))
      dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

   always #5 clk = ~clk;

   always_comb begin
      a1 = bus.imem_addr + 32'd1;
      bus.imem_word0 = mem[bus.imem_addr[9:0]];
      bus.imem_word1 = mem[a1[9:0]];
      a8 = bus8.imem_addr + 8'd1;
      bus8.imem_word0 = mem8[bus8.imem_addr];
      bus8.imem_word1 = mem8[a8];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode, PC and the expected IF/ID contents as plain variables.
   int          m_mode;
   logic [31:0] m_pc, m_ret, m_pcn, m_addr;
   logic        m_pend, m_v;
   logic [15:0] m_instr, m_imm;

   assign m_addr = (m_mode == MB) ? 32'd0 : (m_mode == MI) ? 32'd2 : m_pc;

   always @(posedge clk or negedge rst_n) begin
      logic [15:0] w0, w1;
      logic [31:0] ap, nxt;
      logic        lng;
      if (!rst_n) begin
         m_mode = MB; m_pc = 0; m_pend = 0; m_ret = 0;
         m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0;
      end else begin
         ap  = m_addr + 1;
         w0  = mem[m_addr[9:0]];
         w1  = mem[ap[9:0]];
         lng = LONG_SET[w0[15:11]];
         nxt = m_pc + (lng ? 32'd2 : 32'd1);
         if (m_mode == MB || m_mode == MI) begin
            m_pend = (m_mode == MI) ? bus.int_req : (m_pend | bus.int_req);
            m_pc = {w1, w0};
            m_mode = MR;
            m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0;
         end else begin
            m_pend = m_pend | bus.int_req;
            if (bus.redirect) begin
               m_pc = bus.redirect_pc;
               m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0;
            end else if (m_pend && !bus.stall) begin
               m_ret = m_pc;
               m_mode = MI;
               m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0;
            end else if (bus.stall) begin
               if (bus.flush) begin m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0; end
            end else begin
               if (bus.flush) begin
                  m_v = 0; m_instr = 0; m_imm = 0; m_pcn = 0;
               end else begin
                  m_v = 1; m_instr = w0; m_imm = lng ? w1 : 16'h0; m_pcn = nxt;
               end
               m_pc = nxt;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_pc", bus.pc_out, m_pc);
         chk("mdl_addr", bus.imem_addr, m_addr);
         chk("mdl_valid", 32'(bus.if_id_valid), 32'(m_v));
         chk("mdl_instr", 32'(bus.if_id_instr), 32'(m_instr));
         chk("mdl_imm", 32'(bus.if_id_imm), 32'(m_imm));
         chk("mdl_pcn", bus.if_id_pc_next, m_pcn);
         chk("mdl_ack", 32'(bus.int_ack), 32'(m_mode == MI));
         chk("mdl_ret", bus.int_ret_pc, m_ret);
      end
   end

   task automatic step(input bit st, input bit fl, input bit rd, input logic [31:0] rpc, input bit ir);
      bus.stall = st; bus.flush = fl; bus.redirect = rd; bus.redirect_pc = rpc; bus.int_req = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input logic [31:0] pc, input bit v,
                      input logic [15:0] ins, input logic [15:0] imm);
      chk({nm, "_pc"}, bus.pc_out, pc);
      chk({nm, "_valid"}, 32'(bus.if_id_valid), 32'(v));
      chk({nm, "_instr"}, 32'(bus.if_id_instr), 32'(ins));
      chk({nm, "_imm"}, 32'(bus.if_id_imm), 32'(imm));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'(i & 'h7FF);
      mem[0] = 16'h0020; mem[1] = 16'h0000; mem[2] = 16'h0200; mem[3] = 16'h0000;
      mem[16'h21] = 16'h1800; mem[16'h22] = 16'hBEEF;
      for (int i = 0; i < 256; i++) mem8[i] = 16'h0000;
      mem8[0] = 16'h00FF; mem8[2] = 16'h0040; mem8[8'hFF] = 16'h1800;
      bus.stall = 0; bus.flush = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.int_req = 0;
      bus8.stall = 0; bus8.flush = 0; bus8.redirect = 0; bus8.redirect_pc = 0; bus8.int_req = 0;
      rst_n = 1; rst8_n = 1;
      #2 rst_n = 0; rst8_n = 0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      lit("rst", 32'h0, 0, 16'h0, 16'h0);
      chk("rst_ack", 32'(bus.int_ack), 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);

      rst_n = 1;
      step(0, 0, 0, 0, 0); lit("boot1", 32'h20, 0, 16'h0, 16'h0);
      step(0, 0, 0, 0, 0); lit("nop", 32'h21, 1, 16'h0020, 16'h0);
      chk("nop_pcn", bus.if_id_pc_next, 32'h21);
      step(0, 0, 0, 0, 0); lit("ldm", 32'h23, 1, 16'h1800, 16'hBEEF);
      chk("ldm_pcn", bus.if_id_pc_next, 32'h23);
      step(0, 0, 0, 0, 0); lit("nop2", 32'h24, 1, 16'h0023, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0); lit("stall", 32'h24, 1, 16'h0023, 16'h0);
      end
      step(0, 0, 0, 0, 1); lit("intv", 32'h24, 0, 16'h0, 16'h0);
      chk("intv_ack", 32'(bus.int_ack), 32'h1);
      chk("intv_ret", bus.int_ret_pc, 32'h24);
      chk("intv_addr", bus.imem_addr, 32'h2);
      step(0, 0, 1, 32'h300, 0);
      chk("vec_pc", bus.pc_out, 32'h200);
      chk("vec_ack", 32'(bus.int_ack), 32'h0);
      step(0, 0, 0, 0, 0); lit("isr", 32'h201, 1, 16'h0200, 16'h0);
      step(0, 1, 0, 0, 0); lit("flush", 32'h202, 0, 16'h0, 16'h0);
      step(0, 0, 0, 0, 0); lit("aft_fl", 32'h203, 1, 16'h0202, 16'h0);
      step(1, 1, 0, 0, 0); lit("stfl", 32'h203, 0, 16'h0, 16'h0);
      step(1, 0, 1, 32'h100, 0); lit("redir", 32'h100, 0, 16'h0, 16'h0);
      step(0, 0, 0, 0, 0); lit("tgt", 32'h101, 1, 16'h0100, 16'h0);
      step(1, 0, 0, 0, 1); lit("int_st", 32'h101, 1, 16'h0100, 16'h0);
      chk("int_st_ack", 32'(bus.int_ack), 32'h0);
      step(0, 0, 0, 0, 0);
      chk("int2_ack", 32'(bus.int_ack), 32'h1);
      chk("int2_ret", bus.int_ret_pc, 32'h101);
      step(0, 0, 0, 0, 0);
      chk("int2_pc", bus.pc_out, 32'h200);

      rst8_n = 1;
      step(0, 0, 0, 0, 0);
      chk("w_boot_pc", 32'(bus8.pc_out), 32'hFF);
      step(0, 0, 0, 0, 0);
      chk("w_pc", 32'(bus8.pc_out), 32'h01);
      chk("w_valid", 32'(bus8.if_id_valid), 32'h1);
      chk("w_instr", 32'(bus8.if_id_instr), 32'h1800);
      chk("w_imm", 32'(bus8.if_id_imm), 32'h00FF);
      chk("w_pcn", 32'(bus8.if_id_pc_next), 32'h01);
      bus8.int_req = 1;
      step(0, 0, 0, 0, 0);
      bus8.int_req = 0;
      chk("w_ack", 32'(bus8.int_ack), 32'h1);
      chk("w_ret", 32'(bus8.int_ret_pc), 32'h01);
      chk("w_addr_intv", 32'(bus8.imem_addr), 32'h2);
      rst8_n = 0;
      #1;
      chk("w_rst_pc", 32'(bus8.pc_out), 32'h0);
      chk("w_rst_valid", 32'(bus8.if_id_valid), 32'h0);
      chk("w_rst_instr", 32'(bus8.if_id_instr), 32'h0);
      chk("w_rst_imm", 32'(bus8.if_id_imm), 32'h0);
      chk("w_rst_pcn", 32'(bus8.if_id_pc_next), 32'h0);
      chk("w_rst_ack", 32'(bus8.int_ack), 32'h0);
      chk("w_rst_ret", 32'(bus8.int_ret_pc), 32'h0);
      chk("w_rst_addr", 32'(bus8.imem_addr), 32'h0);

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
